// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte+error FIFO behind the UART receiver; optional UART_RX_FIFO_ALMOST_FULL_EN adds almost_full.
// Latency: write-to-read 1 cycle, show-ahead head. Backpressure: !rd_ready holds the head; a byte arriving while full with no pop is dropped and sets overrun.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_done,
  input  logic                     rx_error,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_err,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overrun,
  input  logic                     clr_overrun
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic                     almost_full
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] dat;
  } entry_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic            push;
  logic            pop;
  logic            drop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign rd_valid = !empty;

  assign pop  = rd_valid && rd_ready;
  assign push = rx_done && (!full || pop);
  assign drop = rx_done && full && !pop;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage is deliberately left out of reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{err: rx_error, dat: rx_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  // A fresh drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (!empty) begin
      rd_data = mem[rd_ptr].dat;
      rd_err  = mem[rd_ptr].err;
    end
  end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);

  if (AF_LEVEL == 0 || AF_LEVEL > DEPTH) begin : g_af_chk
    $error("uart_rx_fifo: AF_LEVEL must be in 1..DEPTH");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nxt >= AF_C);
    end
  end
`else
  if (AF_LEVEL < 0) begin : g_af_chk
    $error("uart_rx_fifo: AF_LEVEL must not be negative");
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: inputs change and outputs are sampled on the falling edge.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_error;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       clr_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_error    (rx_error),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    rx_data  = d;
    rx_error = e;
    rx_done  = 1'b1;
    step();
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_done = 1'b0; rx_error = 1'b0;
    rd_ready = 1'b0; clr_overrun = 1'b0;
    step(); step();

    // reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_err", rd_err, 0);
    rst_n = 1'b1;
    step();

    // three bytes, consumer stalled
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b1);
    push(8'hFF, 1'b0);
    chk("t1_count", count, 3);
    chk("t1_valid", rd_valid, 1);
    chk("t1_head", rd_data, 8'hA5);
    chk("t1_head_err", rd_err, 0);
    step();
    chk("t1_head_stable", rd_data, 8'hA5);
    rd_ready = 1'b1;
    chk("t1_pop0", rd_data, 8'hA5); chk("t1_pop0_err", rd_err, 0);
    step();
    chk("t1_pop1", rd_data, 8'h3C); chk("t1_pop1_err", rd_err, 1);
    step();
    chk("t1_pop2", rd_data, 8'hFF); chk("t1_pop2_err", rd_err, 0);
    step();
    chk("t1_empty", empty, 1);
    chk("t1_count0", count, 0);
    rd_ready = 1'b0;

    // empty latency and simultaneous push/pop at count=1
    rx_data = 8'h11; rx_done = 1'b1;
    chk("t4_valid_T", rd_valid, 0);
    step();
    rx_done = 1'b0;
    chk("t4_valid_T1", rd_valid, 1);
    chk("t4_head", rd_data, 8'h11);
    rx_data = 8'h22; rx_done = 1'b1; rd_ready = 1'b1;
    step();
    rx_done = 1'b0;
    chk("t4_count_pp", count, 1);
    chk("t4_head_pp", rd_data, 8'h22);
    step();
    rd_ready = 1'b0;
    chk("t4_empty", empty, 1);

    // fill, overflow drop, drain
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    chk("t2_full", full, 1);
    chk("t2_count16", count, 16);
    push(8'h55, 1'b0);
    chk("t2_overrun", overrun, 1);
    chk("t2_count_drop", count, 16);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_drain%0d", i), rd_data, 32'(i));
      step();
    end
    rd_ready = 1'b0;
    chk("t2_empty_after", empty, 1);
    chk("t2_overrun_sticky", overrun, 1);

    // drop and clear together, then clear alone
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    rx_data = 8'h66; rx_done = 1'b1; clr_overrun = 1'b1;
    step();
    rx_done = 1'b0;
    chk("t5_set_wins", overrun, 1);
    chk("t5_count", count, 16);
    step();
    clr_overrun = 1'b0;
    chk("t5_cleared", overrun, 0);

    // full with simultaneous pop accepts the push
    rx_data = 8'h77; rx_done = 1'b1; rd_ready = 1'b1;
    step();
    rx_done = 1'b0;
    chk("t3_count", count, 16);
    chk("t3_no_overrun", overrun, 0);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("t3_drain%0d", i), rd_data, 32'(i));
      step();
    end
    chk("t3_last", rd_data, 8'h77);
    step();
    rd_ready = 1'b0;
    chk("t3_empty", empty, 1);

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push(8'(8'h90 + i), 1'b0);
    chk("t6_count5", count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_empty", empty, 1);
    chk("t6_async_count", count, 0);
    chk("t6_async_valid", rd_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    push(8'h81, 1'b0);
    chk("t6_first", rd_data, 8'h81);
    chk("t6_count1", count, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("t6_empty", empty, 1);

    // pointer wrap with streaming push/pop
    push(8'hC0, 1'b0);
    for (int i = 1; i < 40; i++) begin
      chk($sformatf("wrap%0d", i), rd_data, 32'(8'hC0 + i - 1));
      rx_data = 8'(8'hC0 + i); rx_done = 1'b1; rd_ready = 1'b1;
      step();
    end
    rx_done = 1'b0;
    chk("wrap_count", count, 1);
    chk("wrap_last", rd_data, 8'hE7);
    step();
    rd_ready = 1'b0;
    chk("wrap_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
